// File: rtl/cory_tap2fir_pkg.sv
// Shared types and width rules for the serial MAC FIR stage and its round/clip helper.
package cory_tap2fir_pkg;

  // Controller states; encoding kept explicit so reset lands on IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // ceil(log2(v)) with a floor of one bit, so even a single-tap filter owns a counter.
  function automatic int cory_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Signed accumulator width: the N+1 bit signed sample times a C bit coefficient,
  // plus headroom for summing up to 32 taps.
  function automatic int cory_acc_bits(input int n, input int c);
    return n + c + 5;
  endfunction

  // Width used while adding the rounding constant, one guard bit above the
  // accumulator so a near-full-scale positive sum cannot wrap negative.
  function automatic int cory_biased_bits(input int a);
    return a + 1;
  endfunction

endpackage

// File: rtl/cory_rnd_sat.sv
// Combinational round-half-up, arithmetic right shift by S and clip to an unsigned N-bit range.
module cory_rnd_sat
  import cory_tap2fir_pkg::*;
#(
  parameter int A = 21,
  parameter int S = 6,
  parameter int N = 8
) (
  input  logic signed [A-1:0] i_acc,
  output logic        [N-1:0] o_d
);

  localparam int BW = cory_biased_bits(A);
  localparam logic [BW-1:0] HALF = {{(BW-1){1'b0}}, 1'b1} << (S - 1);

  logic signed [BW-1:0] biased;
  logic signed [BW-1:0] shifted;

  assign biased  = {i_acc[A-1], i_acc} + HALF;
  assign shifted = biased >>> S;

  // Negative results clip to zero, anything above the N-bit range clips to full scale.
  always_comb begin
    if (shifted[BW-1]) begin
      o_d = '0;
    end else if (|shifted[BW-2:N]) begin
      o_d = '1;
    end else begin
      o_d = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/cory_tap2fir.sv
// Serial multiply-accumulate FIR stage: one T-sample window in, one rounded/clipped pixel out.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no work held; window port ready
//  MAC     | one tap per cycle into the accumulator, k = 0 .. T-1
//  OUT     | result held on the z port until i_z_r; window port follows i_z_r
module cory_tap2fir
  import cory_tap2fir_pkg::*;
#(
  parameter int N = 8,
  parameter int T = 12,
  parameter int R = 11,
  parameter int C = 10,
  parameter int S = 8,
  parameter int W = N * T,
  parameter int A = cory_acc_bits(N, C)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [T*C-1:0] i_coef,
  input  logic           i_a_v,
  input  logic [W-1:0]   i_a_d,
  input  logic [R-1:0]   i_a_cnt,
  input  logic           i_a_last,
  output logic           o_a_r,
  output logic           o_z_v,
  output logic [N-1:0]   o_z_d,
  output logic [R-1:0]   o_z_cnt,
  output logic           o_z_last,
  input  logic           i_z_r
);

  localparam int KW = cory_clog2(T);
  localparam int PW = N + C + 1;

  fir_state_t state_q, state_d;

  logic [W-1:0]   win_q;
  logic [R-1:0]   win_cnt_q;
  logic           win_last_q;
  logic [KW-1:0]  k_q;
  logic           k_last;
  logic           accept;

  logic signed [A-1:0]  acc_q;
  logic signed [A-1:0]  acc_sum;
  logic        [N-1:0]  smp [T];
  logic signed [C-1:0]  cf  [T];
  logic        [PW-1:0] smp_ext;
  logic        [PW-1:0] cf_ext;
  logic signed [PW-1:0] prod;
  logic        [N-1:0]  sat_d;

  assign accept = i_a_v & o_a_r;
  assign k_last = (k_q == KW'(T - 1));
  assign o_z_v  = (state_q == ST_OUT);

  // Unpack the held window and the live coefficient bus into per-tap views.
  always_comb begin
    for (int j = 0; j < T; j++) begin
      smp[j] = win_q[j*N +: N];
      cf[j]  = $signed(i_coef[j*C +: C]);
    end
  end

  // Samples are unsigned, so zero-extend them; coefficients sign-extend. The
  // true product always fits PW signed bits, so the truncated multiply is exact.
  assign smp_ext = {{C{1'b0}}, smp[k_q]};
  assign cf_ext  = {{(N+1){cf[k_q][C-1]}}, cf[k_q]};
  assign prod    = $signed(smp_ext) * $signed(cf_ext);
  assign acc_sum = acc_q + {{(A-PW){prod[PW-1]}}, prod};

  // Round/clip sees the sum including the final tap, so the result can be
  // registered on the same edge that moves MAC into OUT.
  cory_rnd_sat #(
    .A (A),
    .S (S),
    .N (N)
  ) u_rnd_sat (
    .i_acc (acc_sum),
    .o_d   (sat_d)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and window-ready; ready never looks at i_a_v.
  always_comb begin
    state_d = state_q;
    o_a_r   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_a_r = 1'b1;
        if (i_a_v) begin
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (k_last) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        o_a_r = i_z_r;
        if (i_z_r) begin
          state_d = i_a_v ? ST_MAC : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Window and sideband capture on the input handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q      <= '0;
      win_cnt_q  <= '0;
      win_last_q <= 1'b0;
    end else if (accept) begin
      win_q      <= i_a_d;
      win_cnt_q  <= i_a_cnt;
      win_last_q <= i_a_last;
    end
  end

  // Tap counter and accumulator: cleared on accept, one tap per MAC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == ST_MAC) begin
      acc_q <= acc_sum;
      k_q   <= k_last ? '0 : k_q + KW'(1);
    end
  end

  // Result registers load only on entry to OUT and hold through any stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_z_d    <= '0;
      o_z_cnt  <= '0;
      o_z_last <= 1'b0;
    end else if ((state_q == ST_MAC) && k_last) begin
      o_z_d    <= sat_d;
      o_z_cnt  <= win_cnt_q;
      o_z_last <= win_last_q;
    end
  end

endmodule

// File: tb/tb_cory_tap2fir.sv
// Directed self-checking bench for cory_tap2fir with T=4, N=8, C=8, S=6.
module tb_cory_tap2fir;

  localparam int N = 8;
  localparam int T = 4;
  localparam int R = 11;
  localparam int C = 8;
  localparam int S = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [T*C-1:0] i_coef;
  logic           i_a_v;
  logic [N*T-1:0] i_a_d;
  logic [R-1:0]   i_a_cnt;
  logic           i_a_last;
  logic           o_a_r;
  logic           o_z_v;
  logic [N-1:0]   o_z_d;
  logic [R-1:0]   o_z_cnt;
  logic           o_z_last;
  logic           i_z_r;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cory_tap2fir #(
    .N (N), .T (T), .R (R), .C (C), .S (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_coef   (i_coef),
    .i_a_v    (i_a_v),
    .i_a_d    (i_a_d),
    .i_a_cnt  (i_a_cnt),
    .i_a_last (i_a_last),
    .o_a_r    (o_a_r),
    .o_z_v    (o_z_v),
    .o_z_d    (o_z_d),
    .o_z_cnt  (o_z_cnt),
    .o_z_last (o_z_last),
    .i_z_r    (i_z_r)
  );

  function automatic logic [T*C-1:0] mk_coef(input int c0, input int c1, input int c2, input int c3);
    logic [T*C-1:0] v;
    v[0*C +: C] = C'(c0);
    v[1*C +: C] = C'(c1);
    v[2*C +: C] = C'(c2);
    v[3*C +: C] = C'(c3);
    return v;
  endfunction

  function automatic logic [N*T-1:0] mk_win(input int s0, input int s1, input int s2, input int s3);
    logic [N*T-1:0] v;
    v[0*N +: N] = N'(s0);
    v[1*N +: N] = N'(s1);
    v[2*N +: N] = N'(s2);
    v[3*N +: N] = N'(s3);
    return v;
  endfunction

  // Present a window and return just after the edge that takes it.
  task automatic send_window(input logic [N*T-1:0] d, input int cnt, input bit last, output bit ok);
    ok       = 1'b0;
    i_a_v    = 1'b1;
    i_a_d    = d;
    i_a_cnt  = R'(cnt);
    i_a_last = last;
    for (int i = 0; i < 30; i++) begin
      if (o_a_r) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    i_a_v = 1'b0;
  endtask

  // Count cycles from the handshake cycle until o_z_v shows, bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!o_z_v && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    i_coef   = '0;
    i_a_v    = 1'b0;
    i_a_d    = '0;
    i_a_cnt  = '0;
    i_a_last = 1'b0;
    i_z_r    = 1'b1;
    #1;
    n_chk++; if (o_z_v !== 1'b0) $display("FAIL reset_z_v got %0b want 0", o_z_v); else n_pass++;
    n_chk++; if (o_z_d !== '0) $display("FAIL reset_z_d got %0d want 0", o_z_d); else n_pass++;
    n_chk++; if (o_z_cnt !== '0) $display("FAIL reset_z_cnt got %0d want 0", o_z_cnt); else n_pass++;
    n_chk++; if (o_z_last !== 1'b0) $display("FAIL reset_z_last got %0b want 0", o_z_last); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_chk++; if (o_a_r !== 1'b1) $display("FAIL reset_a_r got %0b want 1", o_a_r); else n_pass++;
  endtask

  task automatic test_unity;
    bit ok;
    int lat;
    i_coef = mk_coef(16, 16, 16, 16);
    send_window(mk_win(100, 100, 100, 100), 3, 1'b0, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL unity_accept got %0b want 1", ok); else n_pass++;
    wait_result(lat);
    n_chk++; if (lat != 5) $display("FAIL unity_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (o_z_d !== 8'd100) $display("FAIL unity_d got %0d want 100", o_z_d); else n_pass++;
    n_chk++; if (o_z_cnt !== 11'd3) $display("FAIL unity_cnt got %0d want 3", o_z_cnt); else n_pass++;
    n_chk++; if (o_z_last !== 1'b0) $display("FAIL unity_last got %0b want 0", o_z_last); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (o_z_v !== 1'b0) $display("FAIL unity_drain got %0b want 0", o_z_v); else n_pass++;
  endtask

  task automatic test_round;
    int cf [4][4] = '{'{1, 0, 0, 0}, '{1, 0, 0, 0}, '{0, 0, 0, 64}, '{64, -1, 0, 0}};
    int sm [4][4] = '{'{32, 200, 7, 99}, '{31, 200, 7, 99}, '{1, 2, 3, 9}, '{1, 32, 0, 0}};
    int ex [4]    = '{1, 0, 9, 1};
    bit ok;
    int lat;
    for (int r = 0; r < 4; r++) begin
      i_coef = mk_coef(cf[r][0], cf[r][1], cf[r][2], cf[r][3]);
      send_window(mk_win(sm[r][0], sm[r][1], sm[r][2], sm[r][3]), r, 1'b0, ok);
      wait_result(lat);
      n_chk++;
      if (o_z_d !== N'(ex[r]) || lat != 5)
        $display("FAIL round[%0d] o_z_d got %0d want %0d (latency %0d want 5)", r, o_z_d, ex[r], lat);
      else n_pass++;
    end
  endtask

  task automatic test_clip;
    int cf [5][4] = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128}, '{64, 0, 0, 0},
                      '{64, -16, 32, -8}, '{0, -1, 0, 0}};
    int sm [5][4] = '{'{255, 255, 255, 255}, '{200, 200, 200, 200}, '{255, 9, 9, 9},
                      '{10, 20, 30, 40}, '{5, 33, 5, 5}};
    int ex [5]    = '{255, 0, 255, 15, 0};
    bit ok;
    int lat;
    for (int r = 0; r < 5; r++) begin
      i_coef = mk_coef(cf[r][0], cf[r][1], cf[r][2], cf[r][3]);
      send_window(mk_win(sm[r][0], sm[r][1], sm[r][2], sm[r][3]), 10 + r, 1'b0, ok);
      wait_result(lat);
      n_chk++;
      if (o_z_d !== N'(ex[r]) || lat != 5)
        $display("FAIL clip[%0d] o_z_d got %0d want %0d (latency %0d want 5)", r, o_z_d, ex[r], lat);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    bit ok;
    int lat;
    int bad_hold = 0;
    int bad_ar   = 0;
    i_coef = mk_coef(16, 16, 16, 16);
    @(posedge clk); #1;
    i_z_r = 1'b0;
    send_window(mk_win(50, 60, 70, 80), 7, 1'b1, ok);
    wait_result(lat);
    n_chk++; if (o_z_d !== 8'd65) $display("FAIL stall_d got %0d want 65", o_z_d); else n_pass++;
    n_chk++; if (o_z_cnt !== 11'd7) $display("FAIL stall_cnt got %0d want 7", o_z_cnt); else n_pass++;
    n_chk++; if (o_z_last !== 1'b1) $display("FAIL stall_last got %0b want 1", o_z_last); else n_pass++;
    i_a_v    = 1'b1;
    i_a_d    = mk_win(10, 10, 10, 10);
    i_a_cnt  = 11'd8;
    i_a_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_z_v !== 1'b1 || o_z_d !== 8'd65 || o_z_cnt !== 11'd7 || o_z_last !== 1'b1) bad_hold++;
      if (o_a_r !== 1'b0) bad_ar++;
    end
    n_chk++; if (bad_hold != 0) $display("FAIL stall_hold got %0d bad cycles want 0", bad_hold); else n_pass++;
    n_chk++; if (bad_ar != 0) $display("FAIL stall_a_r got %0d ready cycles want 0", bad_ar); else n_pass++;
    i_z_r = 1'b1;
    send_window(mk_win(10, 10, 10, 10), 8, 1'b0, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL stall_release_accept got %0b want 1", ok); else n_pass++;
    wait_result(lat);
    n_chk++; if (lat != 5) $display("FAIL stall_next_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (o_z_d !== 8'd10) $display("FAIL stall_next_d got %0d want 10", o_z_d); else n_pass++;
    n_chk++; if (o_z_cnt !== 11'd8) $display("FAIL stall_next_cnt got %0d want 8", o_z_cnt); else n_pass++;
  endtask

  task automatic test_stream;
    int got_d    [20];
    int got_cnt  [20];
    int got_last [20];
    int got_cyc  [20];
    int ng     = 0;
    bit drv_ok = 1'b1;
    i_coef = mk_coef(16, 16, 16, 16);
    i_z_r  = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bit ok;
          int s;
          s = 3 * i + 10;
          send_window(mk_win(s, s + 1, s + 2, s + 3), i, (i == 19), ok);
          if (!ok) drv_ok = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 200 && ng < 20; c++) begin
          @(posedge clk); #1;
          if (o_z_v) begin
            got_d[ng]    = int'(o_z_d);
            got_cnt[ng]  = int'(o_z_cnt);
            got_last[ng] = int'(o_z_last);
            got_cyc[ng]  = cyc;
            ng++;
          end
        end
      end
    join
    n_chk++; if (drv_ok !== 1'b1) $display("FAIL stream_accept got %0b want 1", drv_ok); else n_pass++;
    n_chk++; if (ng != 20) $display("FAIL stream_count got %0d want 20", ng); else n_pass++;
    for (int i = 0; i < ng; i++) begin
      n_chk++;
      if (got_d[i] != 3 * i + 12) $display("FAIL stream_d[%0d] got %0d want %0d", i, got_d[i], 3 * i + 12);
      else n_pass++;
      n_chk++;
      if (got_cnt[i] != i) $display("FAIL stream_cnt[%0d] got %0d want %0d", i, got_cnt[i], i);
      else n_pass++;
      n_chk++;
      if (got_last[i] != ((i == 19) ? 1 : 0))
        $display("FAIL stream_last[%0d] got %0d want %0d", i, got_last[i], (i == 19) ? 1 : 0);
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (got_cyc[i] - got_cyc[i-1] != 5)
          $display("FAIL stream_spacing[%0d] got %0d want 5", i, got_cyc[i] - got_cyc[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat;
    i_coef = mk_coef(16, 16, 16, 16);
    i_z_r  = 1'b1;
    @(posedge clk); #1;
    send_window(mk_win(200, 200, 200, 200), 5, 1'b1, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (o_z_v !== 1'b0) $display("FAIL midreset_z_v got %0b want 0", o_z_v); else n_pass++;
    n_chk++; if (o_z_cnt !== '0) $display("FAIL midreset_z_cnt got %0d want 0", o_z_cnt); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (o_a_r !== 1'b1) $display("FAIL midreset_a_r got %0b want 1", o_a_r); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_z_v !== 1'b0) begin
        n_chk++;
        $display("FAIL midreset_stale_result got o_z_v=%0b d=%0d want no result", o_z_v, o_z_d);
        break;
      end
    end
    send_window(mk_win(40, 40, 40, 40), 9, 1'b0, ok);
    wait_result(lat);
    n_chk++; if (lat != 5) $display("FAIL midreset_latency got %0d want 5", lat); else n_pass++;
    n_chk++; if (o_z_d !== 8'd40) $display("FAIL midreset_d got %0d want 40", o_z_d); else n_pass++;
    n_chk++; if (o_z_cnt !== 11'd9) $display("FAIL midreset_cnt got %0d want 9", o_z_cnt); else n_pass++;
    n_chk++; if (o_z_last !== 1'b0) $display("FAIL midreset_last got %0b want 0", o_z_last); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_unity;
    test_round;
    test_clip;
    test_stall;
    test_stream;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
